// File: rtl/imem_resp.sv
// Fixed-latency instruction-memory responder: one fetch in flight, flush-cancellable, with a load port.
// Define IMEM_ALIGN_CHK_EN to flag odd byte addresses with rsp_err instead of reading memory.
module imem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    input  logic [15:0]       req_addr,
    input  logic              flush,
    output logic              busy,
    output logic              rsp_vld,
    output logic [15:0]       rsp_inst,
    output logic [15:0]       rsp_addr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [15:0] mem [2**ADDR_W];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [15:0] rsp_inst_q, rsp_inst_d;
    logic [15:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0] rd_idx;
    logic [15:0]       rd_word;

    // Asynchronous read paired with a clocked write gives read-before-write on collisions.
    assign rd_idx  = addr_q[ADDR_W:1];
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rsp_vld_d  = 1'b0;
        rsp_inst_d = rsp_inst_q;
        rsp_addr_d = rsp_addr_q;
        rsp_err_d  = rsp_err_q;

        if (state_q == WAIT) begin
            if (flush) begin
                state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d    = IDLE;
                rsp_vld_d  = 1'b1;
                rsp_addr_d = addr_q;
`ifdef IMEM_ALIGN_CHK_EN
                if (addr_q[0]) begin
                    rsp_inst_d = NOP;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_inst_d = rd_word;
                    rsp_err_d  = 1'b0;
                end
`else
                rsp_inst_d = rd_word;
                rsp_err_d  = 1'b0;
`endif
            end
        end

        // A flush frees the slot in the same edge, so the redirect target is taken immediately.
        if (req_vld && (state_q == IDLE || flush)) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            addr_d  = req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            rsp_vld_q  <= 1'b0;
            rsp_inst_q <= NOP;
            rsp_addr_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign busy     = (state_q == WAIT);
    assign rsp_vld  = rsp_vld_q;
    assign rsp_inst = rsp_inst_q;
    assign rsp_addr = rsp_addr_q;
    assign rsp_err  = rsp_err_q;

endmodule
